// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between NUM_REQ byte-stream requesters. Whole packets
// are granted round-robin and never interleaved. Each byte is paced against the
// UART's is_transmitting flag. A requester that goes quiet mid-packet loses its
// lock after TIMEOUT stalled cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_byte,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    input  logic                 is_transmitting,
    output logic                 transmit,
    output logic [7:0]           tx_byte,
    output logic                 timeout_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SEND, PULSE, SETTLE, WAIT} state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PW-1:0]      r_gidx;
    logic [PW-1:0]      r_rrPtr;
    logic [SW-1:0]      r_stall;
    logic               r_last;
    logic               r_transmit;
    logic [7:0]         r_txByte;
    logic               r_timeoutErr;

    logic               w_pickValid;
    logic [PW-1:0]      w_pickIdx;
    logic [PW-1:0]      w_nextPtr;
    logic               w_accept;
    logic               w_stall;

    // Round-robin pick: first valid requester scanning from r_rrPtr upward, wrapping.
    // The scan runs from the far end back so the closest candidate is written last.
    always_comb begin
        int idx;
        idx         = 0;
        w_pickValid = 1'b0;
        w_pickIdx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_rrPtr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                w_pickValid = 1'b1;
                w_pickIdx   = PW'(idx);
            end
        end
    end

    // A byte is taken only from the owner, only in SEND, only with the UART idle.
    // Only a silent owner counts as stalled, so UART busy time never causes a timeout.
    assign w_accept  = (r_state == SEND) && req_valid[r_gidx] && !is_transmitting;
    assign w_stall   = (r_state == SEND) && !req_valid[r_gidx];
    assign w_nextPtr = (int'(r_gidx) == NUM_REQ - 1) ? '0 : r_gidx + 1'b1;
    assign req_ready = w_accept ? r_grant : '0;

    assign grant       = r_grant;
    assign transmit    = r_transmit;
    assign tx_byte     = r_txByte;
    assign timeout_err = r_timeoutErr;

    // Packet FSM: lock a requester, hand its bytes to the UART one at a time,
    // and release the lock on the last byte or on a stall timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_rrPtr      <= '0;
            r_stall      <= '0;
            r_last       <= 1'b0;
            r_transmit   <= 1'b0;
            r_txByte     <= 8'h00;
            r_timeoutErr <= 1'b0;
        end else begin
            r_transmit   <= 1'b0;
            r_timeoutErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pickValid) begin
                        r_grant <= NUM_REQ'(1) << w_pickIdx;
                        r_gidx  <= w_pickIdx;
                        r_stall <= '0;
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        r_txByte   <= req_byte[8*r_gidx +: 8];
                        r_transmit <= 1'b1;
                        r_last     <= req_last[r_gidx];
                        r_stall    <= '0;
                        r_state    <= PULSE;
                    end else if (w_stall) begin
                        if (r_stall >= SW'(TIMEOUT - 1)) begin
                            r_timeoutErr <= 1'b1;
                            r_grant      <= '0;
                            r_rrPtr      <= w_nextPtr;
                            r_stall      <= '0;
                            r_state      <= IDLE;
                        end else begin
                            r_stall <= r_stall + 1'b1;
                        end
                    end
                end
                PULSE: begin
                    r_state <= SETTLE;
                end
                SETTLE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (!is_transmitting) begin
                        if (r_last) begin
                            r_grant <= '0;
                            r_rrPtr <= w_nextPtr;
                            r_state <= IDLE;
                        end else begin
                            r_stall <= '0;
                            r_state <= SEND;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter with two requesters and TIMEOUT=8. The first part is a
// cycle-by-cycle vector table for reset and a first packet. The second part uses queue-fed
// requesters and a small UART busy model for round-robin, backpressure, timeout and
// mid-packet reset.
module tb_uart_tx_arbiter;

    localparam int BUSY_LEN = 4;
    localparam int NVEC     = 20;

    logic        clock;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [15:0] req_byte;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic        is_transmitting;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        timeout_err;

    uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT(8)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_byte        (req_byte),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .grant           (grant),
        .is_transmitting (is_transmitting),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .timeout_err     (timeout_err)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rstN;
        logic [1:0] valid;
        logic [7:0] byte0;
        logic       last0;
        logic       busy;
        logic [1:0] expGrant;
        logic [1:0] expReady;
        logic       expTransmit;
        logic [7:0] expTx;
        logic       expTerr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } item_t;

    vec_t       vecs[NVEC];
    item_t      q0[$];
    item_t      q1[$];
    logic [7:0] obsByte[$];
    logic [1:0] obsGrant[$];
    int         obsCycle[$];

    int   checks;
    int   errors;
    int   cycleNo;
    int   busyCnt;
    logic forceBusy;
    int   readyCnt;
    int   txCnt;
    int   terrCount;
    int   terrCycle;
    logic [1:0] terrGrant;

    function automatic vec_t mkVec(input logic rstN, input logic [1:0] valid, input logic [7:0] byte0,
                                   input logic last0, input logic busy, input logic [1:0] expGrant,
                                   input logic [1:0] expReady, input logic expTransmit,
                                   input logic [7:0] expTx);
        vec_t v;
        v.rstN        = rstN;
        v.valid       = valid;
        v.byte0       = byte0;
        v.last0       = last0;
        v.busy        = busy;
        v.expGrant    = expGrant;
        v.expReady    = expReady;
        v.expTransmit = expTransmit;
        v.expTx       = expTx;
        v.expTerr     = 1'b0;
        return v;
    endfunction

    function automatic item_t mkItem(input logic [7:0] data, input logic last);
        item_t it;
        it.data = data;
        it.last = last;
        return it;
    endfunction

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Table requester 1 always offers a single-byte packet 'hAA.
    task automatic applyStimulus(input vec_t v);
        @(posedge clock);
        #1;
        reset_n         = v.rstN;
        req_valid       = v.valid;
        req_byte        = {8'hAA, v.byte0};
        req_last        = {1'b1, v.last0};
        is_transmitting = v.busy;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        @(negedge clock);
        compare($sformatf("vec%0d.grant", idx), 32'(grant), 32'(v.expGrant));
        compare($sformatf("vec%0d.ready", idx), 32'(req_ready), 32'(v.expReady));
        compare($sformatf("vec%0d.transmit", idx), 32'(transmit), 32'(v.expTransmit));
        compare($sformatf("vec%0d.txByte", idx), 32'(tx_byte), 32'(v.expTx));
        compare($sformatf("vec%0d.timeoutErr", idx), 32'(timeout_err), 32'(v.expTerr));
    endtask

    task automatic driveInputs();
        req_valid       = {q1.size() > 0, q0.size() > 0};
        req_byte        = {(q1.size() > 0) ? q1[0].data : 8'h00, (q0.size() > 0) ? q0[0].data : 8'h00};
        req_last        = {(q1.size() > 0) ? q1[0].last : 1'b0, (q0.size() > 0) ? q0[0].last : 1'b0};
        is_transmitting = forceBusy || (busyCnt != 0);
    endtask

    // One model cycle: sample mid-cycle, then pop accepted bytes and advance the UART after the edge.
    task automatic tick();
        logic [1:0] sReady;
        logic       sTransmit;
        @(negedge clock);
        cycleNo++;
        sReady    = req_ready;
        sTransmit = transmit;
        compare("lockInvariant",
                32'($onehot0(req_ready) && ((req_ready & ~grant) == 2'b00) && $onehot0(grant)), 32'd1);
        if (transmit) begin
            obsByte.push_back(tx_byte);
            obsGrant.push_back(grant);
            obsCycle.push_back(cycleNo);
            txCnt++;
        end
        if (req_ready != 2'b00) readyCnt++;
        if (timeout_err) begin
            terrCount++;
            terrCycle = cycleNo;
            terrGrant = grant;
        end
        @(posedge clock);
        #1;
        if (sReady[0] && q0.size() > 0) void'(q0.pop_front());
        if (sReady[1] && q1.size() > 0) void'(q1.pop_front());
        if (sTransmit) busyCnt = BUSY_LEN;
        else if (busyCnt > 0) busyCnt--;
        driveInputs();
    endtask

    task automatic holdReset();
        reset_n         = 1'b0;
        req_valid       = 2'b11;
        req_byte        = 16'hFFFF;
        req_last        = 2'b00;
        is_transmitting = 1'b0;
        q0.delete();
        q1.delete();
        obsByte.delete();
        obsGrant.delete();
        obsCycle.delete();
        busyCnt   = 0;
        forceBusy = 1'b0;
        readyCnt  = 0;
        txCnt     = 0;
        terrCount = 0;
        terrCycle = 0;
        terrGrant = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            compare("rstGrant", 32'(grant), 32'd0);
            compare("rstReady", 32'(req_ready), 32'd0);
            compare("rstTransmit", 32'(transmit), 32'd0);
        end
        compare("rstTxByte", 32'(tx_byte), 32'd0);
        compare("rstTimeoutErr", 32'(timeout_err), 32'd0);
    endtask

    task automatic releaseReset();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        driveInputs();
    endtask

    task automatic runUntilDrained(input int maxCycles, input int nTx, input string tag);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && obsByte.size() >= nTx &&
                 grant == 2'b00 && busyCnt == 0) && n < maxCycles) begin
            tick();
            n++;
        end
        checks++;
        if (n >= maxCycles) begin
            errors++;
            $display("[TB] FAIL %s.drain: still busy after %0d cycles, required done within %0d",
                     tag, n, maxCycles);
        end
    endtask

    task automatic expectTx(input string tag, input int i, input logic [7:0] b, input logic [1:0] g);
        if (i < obsByte.size()) begin
            compare($sformatf("%s.byte%0d", tag, i), 32'(obsByte[i]), 32'(b));
            compare($sformatf("%s.grant%0d", tag, i), 32'(obsGrant[i]), 32'(g));
        end else begin
            compare($sformatf("%s.count", tag), 32'(obsByte.size()), 32'(i + 1));
        end
    endtask

    // Bound on total run time so a stuck DUT still ends the simulation.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: vector table first, then the model-driven corner cases.
    initial begin
        checks          = 0;
        errors          = 0;
        cycleNo         = 0;
        busyCnt         = 0;
        forceBusy       = 1'b0;
        readyCnt        = 0;
        txCnt           = 0;
        terrCount       = 0;
        terrCycle       = 0;
        terrGrant       = 2'b11;
        reset_n         = 1'b0;
        req_valid       = 2'b11;
        req_byte        = 16'h0000;
        req_last        = 2'b00;
        is_transmitting = 1'b0;

        //                rstN valid  byte0  l0    busy  grant  ready  tx    txByte
        vecs[0]  = mkVec(1'b0, 2'b11, 8'h0E, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00);
        vecs[1]  = mkVec(1'b0, 2'b11, 8'h0E, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00);
        vecs[2]  = mkVec(1'b1, 2'b11, 8'h0E, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00);
        vecs[3]  = mkVec(1'b1, 2'b11, 8'h0E, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 8'h00);
        vecs[4]  = mkVec(1'b1, 2'b11, 8'hCD, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 8'h0E);
        vecs[5]  = mkVec(1'b1, 2'b11, 8'hCD, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 8'h0E);
        vecs[6]  = mkVec(1'b1, 2'b11, 8'hCD, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 8'h0E);
        vecs[7]  = mkVec(1'b1, 2'b11, 8'hCD, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 8'h0E);
        vecs[8]  = mkVec(1'b1, 2'b11, 8'hCD, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 8'h0E);
        vecs[9]  = mkVec(1'b1, 2'b11, 8'hCD, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 8'h0E);
        vecs[10] = mkVec(1'b1, 2'b11, 8'h42, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 8'hCD);
        vecs[11] = mkVec(1'b1, 2'b11, 8'h42, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 8'hCD);
        vecs[12] = mkVec(1'b1, 2'b11, 8'h42, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 8'hCD);
        vecs[13] = mkVec(1'b1, 2'b11, 8'h42, 1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 8'hCD);
        vecs[14] = mkVec(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 8'h42);
        vecs[15] = mkVec(1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 8'h42);
        vecs[16] = mkVec(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 8'h42);
        vecs[17] = mkVec(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 8'h42);
        vecs[18] = mkVec(1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 8'h42);
        vecs[19] = mkVec(1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 8'hAA);

        $display("[TB] vector table: reset, single packet 0E/CD/42, lock, hand-over to req1");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        $display("[TB] round-robin: two packets on req0, one on req1");
        holdReset();
        q0.push_back(mkItem(8'h10, 1'b0));
        q0.push_back(mkItem(8'h11, 1'b1));
        q0.push_back(mkItem(8'h12, 1'b0));
        q0.push_back(mkItem(8'h13, 1'b1));
        q1.push_back(mkItem(8'h20, 1'b0));
        q1.push_back(mkItem(8'h21, 1'b1));
        releaseReset();
        runUntilDrained(300, 6, "rr");
        compare("rr.count", 32'(obsByte.size()), 32'd6);
        expectTx("rr", 0, 8'h10, 2'b01);
        expectTx("rr", 1, 8'h11, 2'b01);
        expectTx("rr", 2, 8'h20, 2'b10);
        expectTx("rr", 3, 8'h21, 2'b10);
        expectTx("rr", 4, 8'h12, 2'b01);
        expectTx("rr", 5, 8'h13, 2'b01);
        compare("rr.timeoutErr", 32'(terrCount), 32'd0);

        $display("[TB] backpressure: UART busy for 20 cycles");
        holdReset();
        forceBusy = 1'b1;
        q0.push_back(mkItem(8'h55, 1'b0));
        q0.push_back(mkItem(8'h66, 1'b1));
        releaseReset();
        for (int i = 0; i < 20; i++) tick();
        compare("bp.readyWhileBusy", 32'(readyCnt), 32'd0);
        compare("bp.transmitWhileBusy", 32'(txCnt), 32'd0);
        compare("bp.grantHeld", 32'(grant), 32'd1);
        forceBusy = 1'b0;
        driveInputs();
        runUntilDrained(200, 2, "bp");
        compare("bp.count", 32'(obsByte.size()), 32'd2);
        expectTx("bp", 0, 8'h55, 2'b01);
        expectTx("bp", 1, 8'h66, 2'b01);
        compare("bp.timeoutErr", 32'(terrCount), 32'd0);

        $display("[TB] timeout: req0 abandons its packet, req1 waiting");
        holdReset();
        q0.push_back(mkItem(8'h77, 1'b0));
        q1.push_back(mkItem(8'h88, 1'b1));
        releaseReset();
        runUntilDrained(200, 2, "to");
        compare("to.pulses", 32'(terrCount), 32'd1);
        // PULSE cycle to timeout_err: 1 SETTLE + 4 WAIT + 8 stalled SEND + 1.
        compare("to.gap", (obsCycle.size() > 0) ? 32'(terrCycle - obsCycle[0]) : 32'hFFFF_FFFF, 32'd14);
        compare("to.grantAtErr", 32'(terrGrant), 32'd0);
        expectTx("to", 0, 8'h77, 2'b01);
        expectTx("to", 1, 8'h88, 2'b10);

        $display("[TB] reset asserted while waiting on the UART");
        holdReset();
        q0.push_back(mkItem(8'h99, 1'b0));
        q0.push_back(mkItem(8'h9A, 1'b1));
        releaseReset();
        begin
            int n;
            n = 0;
            while (obsByte.size() == 0 && n < 50) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 50) begin
                errors++;
                $display("[TB] FAIL mid.firstByte: no transmit after %0d cycles, required within 50", n);
            end
        end
        tick();
        compare("mid.grantBefore", 32'(grant), 32'd1);
        compare("mid.txByteBefore", 32'(tx_byte), 32'h99);
        reset_n = 1'b0;
        #1;
        compare("mid.grant", 32'(grant), 32'd0);
        compare("mid.ready", 32'(req_ready), 32'd0);
        compare("mid.transmit", 32'(transmit), 32'd0);
        compare("mid.txByte", 32'(tx_byte), 32'd0);
        compare("mid.timeoutErr", 32'(timeout_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
